// File: rtl/mealy_seq_detector_pkg.sv
// Shared constants and helpers for the parametrised Mealy sequence detector.
package mealy_pkg;

  localparam logic [3:0] DEFAULT_PATTERN_4 = 4'b1011;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 32'sd1;
    end
    if (result < 32'sd1) begin
      result = 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mealy_seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  logic [WIDTH-1:0] count_d, count_q;
  logic             sat_d, sat_q;

  // Next count: clear beats increment, increment stops at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q;
    end
    sat_d = (count_d == {WIDTH{1'b1}});
  end

  // Counter and saturation flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/mealy_seq_detector.sv
// Mealy detector for a runtime-loadable PAT_WIDTH-bit serial pattern with
// optional overlap and a saturating match counter.
module mealy_seq_detector
  import mealy_pkg::*;
#(
  parameter int                   PAT_WIDTH       = 4,
  parameter logic [PAT_WIDTH-1:0] DEFAULT_PATTERN = DEFAULT_PATTERN_4,
  parameter bit                   OVERLAP         = 1'b1,
  parameter int                   CNT_WIDTH       = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ain,
  input  logic                 ain_valid,
  input  logic [PAT_WIDTH-1:0] pattern_in,
  input  logic                 pattern_load,
  input  logic                 count_clear,
  output logic                 aout,
  output logic                 aout_q,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic                 count_sat
);

  localparam int                FILL_W   = clog2(PAT_WIDTH);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_WIDTH - 1);

  logic [PAT_WIDTH-1:0] pattern_d, pattern_q;
  logic [PAT_WIDTH-2:0] hist_d, hist_q;
  logic [FILL_W-1:0]    fill_d, fill_q;
  logic                 aout_d, aout_r_q;
  logic [PAT_WIDTH-1:0] window_s;
  logic                 match_s;

  // Candidate window: stored history plus the bit arriving this cycle.
  assign window_s = {hist_q, ain};
  assign match_s  = ain_valid & ~pattern_load & (fill_q == FILL_MAX) & (window_s == pattern_q);
  assign aout     = match_s & reset;

  // Pattern, history and fill updates; a load discards the same-cycle sample.
  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    aout_d    = aout;
    if (pattern_load) begin
      pattern_d = pattern_in;
      hist_d    = '0;
      fill_d    = '0;
    end else if (ain_valid) begin
      hist_d = window_s[PAT_WIDTH-2:0];
      if (!OVERLAP && aout) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end else begin
        fill_d = fill_q;
      end
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
  end

  // Detector state and registered copy of the match flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pattern_q <= DEFAULT_PATTERN;
      hist_q    <= '0;
      fill_q    <= '0;
      aout_r_q  <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      aout_r_q  <= aout_d;
    end
  end

  assign aout_q = aout_r_q;

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_match_cnt (
    .clk  (clock),
    .rst_n(reset),
    .inc  (aout),
    .clr  (count_clear),
    .count(match_count),
    .sat  (count_sat)
  );

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Directed bench: overlap, non-overlap and 2-bit-counter instances share one stimulus stream.
module tb_mealy_seq_detector;

  logic       clock = 1'b0;
  logic       reset;
  logic       ain;
  logic       ain_valid;
  logic [3:0] pattern_in;
  logic       pattern_load;
  logic       count_clear;

  logic       aout_ov, aout_q_ov, sat_ov;
  logic [7:0] cnt_ov;
  logic       aout_nov, aout_q_nov, sat_nov;
  logic [7:0] cnt_nov;
  logic       aout_sat, aout_q_sat, sat_sat;
  logic [1:0] cnt_sat;

  logic ao_ov, ao_nov, ao_sat;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  mealy_seq_detector #(.OVERLAP(1'b1)) u_ov (
    .clock(clock), .reset(reset), .ain(ain), .ain_valid(ain_valid),
    .pattern_in(pattern_in), .pattern_load(pattern_load), .count_clear(count_clear),
    .aout(aout_ov), .aout_q(aout_q_ov), .match_count(cnt_ov), .count_sat(sat_ov));

  mealy_seq_detector #(.OVERLAP(1'b0)) u_nov (
    .clock(clock), .reset(reset), .ain(ain), .ain_valid(ain_valid),
    .pattern_in(pattern_in), .pattern_load(pattern_load), .count_clear(count_clear),
    .aout(aout_nov), .aout_q(aout_q_nov), .match_count(cnt_nov), .count_sat(sat_nov));

  mealy_seq_detector #(.OVERLAP(1'b1), .CNT_WIDTH(2)) u_sat (
    .clock(clock), .reset(reset), .ain(ain), .ain_valid(ain_valid),
    .pattern_in(pattern_in), .pattern_load(pattern_load), .count_clear(count_clear),
    .aout(aout_sat), .aout_q(aout_q_sat), .match_count(cnt_sat), .count_sat(sat_sat));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, capture aout mid-cycle, return just after the edge.
  task automatic cyc(input logic a, input logic v, input logic ld, input logic [3:0] pin,
                     input logic clr);
    ain          = a;
    ain_valid    = v;
    pattern_load = ld;
    pattern_in   = pin;
    count_clear  = clr;
    @(negedge clock);
    ao_ov  = aout_ov;
    ao_nov = aout_nov;
    ao_sat = aout_sat;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [6:0]  st;
    logic [6:0]  e_ov;
    logic [6:0]  e_nov;
    logic [3:0]  g;
    logic [15:0] s3;
    logic [15:0] m3;
    logic [1:0]  c3;
    logic        e;

    reset        = 1'b0;
    ain          = 1'b0;
    ain_valid    = 1'b0;
    pattern_in   = 4'h0;
    pattern_load = 1'b0;
    count_clear  = 1'b0;
    #2;
    chk("rst_low_aout", {7'd0, aout_ov}, 8'd0);
    #8;
    reset = 1'b1;
    #1;
    chk("rst_aout", {7'd0, aout_ov}, 8'd0);
    chk("rst_aout_q", {7'd0, aout_q_ov}, 8'd0);
    chk("rst_count", cnt_ov, 8'd0);
    chk("rst_sat", {7'd0, sat_ov}, 8'd0);
    chk("rst_pattern", {4'd0, u_ov.pattern_q}, 8'h0b);
    @(posedge clock);
    #1;

    // Overlap vs non-overlap on 1011011
    st    = 7'b1011011;
    e_ov  = 7'b0001001;
    e_nov = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      cyc(st[i], 1'b1, 1'b0, 4'h0, 1'b0);
      chk("ovl_aout", {7'd0, ao_ov}, {7'd0, e_ov[i]});
      chk("novl_aout", {7'd0, ao_nov}, {7'd0, e_nov[i]});
      chk("ovl_aout_q", {7'd0, aout_q_ov}, {7'd0, e_ov[i]});
    end
    chk("ovl_count", cnt_ov, 8'd2);
    chk("novl_count", cnt_nov, 8'd1);

    cyc(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
    chk("clr_count", cnt_ov, 8'd0);

    // Valid gaps are transparent
    g = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      e = (i == 0);
      cyc(g[i], 1'b1, 1'b0, 4'h0, 1'b0);
      chk("gap_aout", {7'd0, ao_ov}, {7'd0, e});
      for (int k = 0; k < 3; k++) begin
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        chk("gap_idle_aout", {7'd0, ao_ov}, 8'd0);
      end
    end
    chk("gap_count", cnt_ov, 8'd1);

    cyc(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    chk("load_aout", {7'd0, ao_ov}, 8'd0);
    chk("load_count", cnt_ov, 8'd1);
    g = 4'b0110;
    for (int i = 3; i >= 0; i--) begin
      e = (i == 0);
      cyc(g[i], 1'b1, 1'b0, 4'h0, 1'b0);
      chk("reload_aout", {7'd0, ao_ov}, {7'd0, e});
      chk("reload_aout_nov", {7'd0, ao_nov}, {7'd0, e});
    end
    chk("reload_count", cnt_ov, 8'd2);
    chk("reload_count_nov", cnt_nov, 8'd2);

    // Saturation of the 2-bit counter: matches on bits 4,7,10,13,16
    cyc(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
    chk("sat_cleared", {6'd0, cnt_sat}, 8'd0);
    s3 = 16'b1011011011011011;
    m3 = 16'b0001001001001001;
    c3 = 2'd0;
    for (int i = 15; i >= 0; i--) begin
      cyc(s3[i], 1'b1, 1'b0, 4'h0, 1'b0);
      chk("sat_aout", {7'd0, ao_sat}, {7'd0, m3[i]});
      if (m3[i] && c3 != 2'd3) c3 = c3 + 2'd1;
      chk("sat_count", {6'd0, cnt_sat}, {6'd0, c3});
      chk("sat_flag", {7'd0, sat_sat}, {7'd0, (c3 == 2'd3)});
    end
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    chk("clr_vs_match_aout", {7'd0, ao_sat}, 8'd1);
    chk("clr_vs_match_count", {6'd0, cnt_sat}, 8'd0);
    chk("clr_vs_match_flag", {7'd0, sat_sat}, 8'd0);

    // Asynchronous reset mid-stream restores the default pattern
    cyc(1'b0, 1'b0, 1'b1, 4'b0110, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    ain_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_count", cnt_ov, 8'd0);
    chk("async_rst_pattern", {4'd0, u_ov.pattern_q}, 8'h0b);
    chk("async_rst_aout_q", {7'd0, aout_q_ov}, 8'd0);
    #2;
    reset = 1'b1;
    st = 7'b0011011;
    for (int i = 4; i >= 0; i--) begin
      e = (i == 0);
      cyc(st[i], 1'b1, 1'b0, 4'h0, 1'b0);
      chk("post_rst_aout", {7'd0, ao_ov}, {7'd0, e});
    end
    chk("post_rst_aout_q", {7'd0, aout_q_ov}, 8'd1);
    chk("post_rst_count", cnt_ov, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
